// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encodings,
// the read mask value and byte-lane constants.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    API_DMEM_IDLE = 2'd0,
    API_DMEM_WAIT = 2'd1,
    API_DMEM_RESP = 2'd2
  } dmem_state_e;

  localparam logic [3:0]  API_DMEM_MASK_READ = 4'b0000;
  localparam int unsigned API_DMEM_LANES     = 4;
  localparam int unsigned API_DMEM_CNT_W     = 4;

endpackage

// File: rtl/dmem_responder_array.sv
// Single-port word storage with per-byte write enables and a registered read.
// The read returns the word as it was before any write on the same edge.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                      clk,
  input  logic                      en_i,
  input  logic [API_DMEM_LANES-1:0] we_i,
  input  logic [IDX_W-1:0]          idx_i,
  input  logic [31:0]               wdata_i,
  output logic [31:0]               rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int unsigned k = 0; k < API_DMEM_LANES; k++) begin
        if (we_i[k]) begin
          mem_q[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, waits WAIT_STATES cycles, then
// pulses ready_o with read data or an error. Optional counters: API_DMEM_STATS_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [3:0]            wr_mask_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  ready_o,
  output logic                  err_o
`ifdef API_DMEM_STATS_EN
  ,
  output logic [31:0]           rd_count_o,
  output logic [31:0]           wr_count_o
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] WINDOW_BYTES =
    (ADDR_WIDTH+1)'(64'(DEPTH_WORDS) << 2);
  localparam logic [API_DMEM_CNT_W-1:0] WAIT_INIT = API_DMEM_CNT_W'(WAIT_STATES);

  dmem_state_e               state_q, state_d;
  logic [API_DMEM_CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [3:0]                mask_q, mask_d;
  logic [DATA_WIDTH-1:0]     hold_q, hold_d;

  logic [ADDR_WIDTH-1:0]     cur_addr;
  logic [DATA_WIDTH-1:0]     cur_wdata;
  logic [3:0]                cur_mask;
  logic [ADDR_WIDTH-1:0]     offset;
  logic [IDX_W-1:0]          idx;
  logic                      req_err;
  logic                      is_read;
  logic                      arr_en;
  logic [3:0]                arr_we;
  logic [DATA_WIDTH-1:0]     arr_rdata;

  // With zero wait states the array is accessed on the accept edge itself,
  // before the request registers are loaded, so decode from the live inputs.
  always_comb begin
    if (state_q == API_DMEM_IDLE) begin
      cur_addr  = addr_i;
      cur_wdata = data_i;
      cur_mask  = wr_mask_i;
    end else begin
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_mask  = mask_q;
    end
    offset  = cur_addr - BASE_ADDR;
    idx     = offset[IDX_W+1:2];
    req_err = (cur_addr[1:0] != 2'b00) || (cur_addr < BASE_ADDR) ||
              ({1'b0, offset} >= WINDOW_BYTES);
    is_read = (cur_mask == API_DMEM_MASK_READ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= API_DMEM_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    unique case (state_q)
      API_DMEM_IDLE: begin
        if (en_i) begin
          addr_d  = addr_i;
          wdata_d = data_i;
          mask_d  = wr_mask_i;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_STATES == 0) ? API_DMEM_RESP : API_DMEM_WAIT;
        end
      end
      API_DMEM_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 4'd1) begin
          state_d = API_DMEM_RESP;
        end
      end
      API_DMEM_RESP: state_d = API_DMEM_IDLE;
      default:       state_d = API_DMEM_IDLE;
    endcase
  end

  // Storage is touched only on the edge that enters RESP; gating with reset
  // keeps a request from landing while the FSM is being cleared.
  always_comb begin
    ready_o = (state_q == API_DMEM_RESP);
    err_o   = ready_o && req_err;
    arr_en  = (state_d == API_DMEM_RESP) && !reset;
    arr_we  = (arr_en && !req_err) ? cur_mask : '0;
    if (ready_o && req_err) begin
      data_o = '0;
    end else if (ready_o && is_read) begin
      data_o = arr_rdata;
    end else begin
      data_o = hold_q;
    end
    hold_d = (ready_o && is_read) ? data_o : hold_q;
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk    (clk),
    .en_i   (arr_en),
    .we_i   (arr_we),
    .idx_i  (idx),
    .wdata_i(cur_wdata),
    .rdata_o(arr_rdata)
  );

`ifdef API_DMEM_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (ready_o && !req_err) begin
      if (is_read && (rd_cnt_q != '1)) begin
        rd_cnt_d = rd_cnt_q + 32'd1;
      end
      if (!is_read && (wr_cnt_q != '1)) begin
        wr_cnt_d = wr_cnt_q + 32'd1;
      end
    end
  end

  assign rd_count_o = rd_cnt_q;
  assign wr_count_o = wr_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders (1, 0 and 3 wait states) checked against
// hand-computed latencies, data and error flags.
module tb_dmem_responder;

  logic        clk;
  logic        rst   [3];
  logic        en    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  mask  [3];
  logic [31:0] rdata [3];
  logic        rdy   [3];
  logic        err   [3];
`ifdef API_DMEM_STATS_EN
  logic [31:0] rdc [3];
  logic [31:0] wrc [3];
`endif

  int n_chk = 0;
  int n_err = 0;

  dmem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024),
    .BASE_ADDR(32'h0000_0000), .WAIT_STATES(1)
  ) u_ws1 (
    .clk(clk), .reset(rst[0]), .en_i(en[0]), .addr_i(addr[0]), .data_i(wdata[0]),
    .wr_mask_i(mask[0]), .data_o(rdata[0]), .ready_o(rdy[0]), .err_o(err[0])
`ifdef API_DMEM_STATS_EN
    , .rd_count_o(rdc[0]), .wr_count_o(wrc[0])
`endif
  );

  dmem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(16),
    .BASE_ADDR(32'h0000_0100), .WAIT_STATES(0)
  ) u_ws0 (
    .clk(clk), .reset(rst[1]), .en_i(en[1]), .addr_i(addr[1]), .data_i(wdata[1]),
    .wr_mask_i(mask[1]), .data_o(rdata[1]), .ready_o(rdy[1]), .err_o(err[1])
`ifdef API_DMEM_STATS_EN
    , .rd_count_o(rdc[1]), .wr_count_o(wrc[1])
`endif
  );

  dmem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024),
    .BASE_ADDR(32'h0000_0000), .WAIT_STATES(3)
  ) u_ws3 (
    .clk(clk), .reset(rst[2]), .en_i(en[2]), .addr_i(addr[2]), .data_i(wdata[2]),
    .wr_mask_i(mask[2]), .data_o(rdata[2]), .ready_o(rdy[2]), .err_o(err[2])
`ifdef API_DMEM_STATS_EN
    , .rd_count_o(rdc[2]), .wr_count_o(wrc[2])
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for ready, then return to IDLE.
  task automatic req(input int d, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] m, output logic [31:0] rd, output logic er,
                     output int lat);
    logic seen;
    en[d] = 1'b1; addr[d] = a; wdata[d] = wd; mask[d] = m;
    lat = 0; rd = '0; er = 1'b0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (rdy[d]) begin
        seen = 1'b1;
        rd   = rdata[d];
        er   = err[d];
        break;
      end
    end
    chk("ready_seen", 32'(seen), 32'd1);
    en[d] = 1'b0; mask[d] = 4'b0000;
    @(posedge clk); #1;
    chk("ready_one_cycle", 32'(rdy[d]), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          pulses;
  int          k;
  logic [31:0] vals [4];

  initial begin
    vals = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; en[d] = 1'b0; addr[d] = '0; wdata[d] = '0; mask[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_ready", 32'(rdy[d]), 32'd0);
      chk("reset_err",   32'(err[d]), 32'd0);
      chk("reset_data",  rdata[d],    32'd0);
    end
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    @(posedge clk); #1;

    // One wait state: full-word write/read, byte masks, errors, data hold.
    req(0, 32'h10, 32'hDEAD_BEEF, 4'b1111, rd, er, lat);
    chk("ws1_wr_lat", 32'(lat), 32'd2);
    chk("ws1_wr_err", 32'(er), 32'd0);
    req(0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
    chk("ws1_rd_lat", 32'(lat), 32'd2);
    chk("ws1_rd_data", rd, 32'hDEAD_BEEF);
    chk("ws1_rd_err", 32'(er), 32'd0);
    req(0, 32'h20, 32'h1122_3344, 4'b1111, rd, er, lat);
    req(0, 32'h20, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
    chk("mask_wr_err", 32'(er), 32'd0);
    req(0, 32'h20, 32'h0, 4'b0000, rd, er, lat);
    chk("mask_rd_data", rd, 32'h11BB_33DD);
    req(0, 32'h10, 32'h0, 4'b1111, rd, er, lat);
    chk("hold_over_write", rd, 32'h11BB_33DD);
    req(0, 32'h22, 32'h0, 4'b0000, rd, er, lat);
    chk("misalign_err", 32'(er), 32'd1);
    chk("misalign_data", rd, 32'd0);
    req(0, 32'h1000, 32'h0, 4'b0000, rd, er, lat);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_data", rd, 32'd0);
    req(0, 32'h21, 32'hFFFF_FFFF, 4'b1111, rd, er, lat);
    chk("misalign_wr_err", 32'(er), 32'd1);
    req(0, 32'h20, 32'h0, 4'b0000, rd, er, lat);
    chk("after_err_data", rd, 32'h11BB_33DD);
    chk("after_err_err", 32'(er), 32'd0);
    req(0, 32'hFFC, 32'h0, 4'b0000, rd, er, lat);
    chk("last_word_err", 32'(er), 32'd0);

    // Zero wait states, window 0x100..0x13F.
    for (int i = 0; i < 4; i++) begin
      req(1, 32'h100 + 32'(4*i), vals[i], 4'b1111, rd, er, lat);
      chk("ws0_wr_lat", 32'(lat), 32'd1);
    end
    en[1] = 1'b1; addr[1] = 32'h100; mask[1] = 4'b0000;
    pulses = 0; k = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk("b2b_ready", 32'(rdy[1]), 32'((c % 2) == 0));
      if (rdy[1]) begin
        pulses++;
        if (k < 4) begin
          chk("b2b_data", rdata[1], vals[k]);
          k++;
          addr[1] = 32'h100 + 32'(4*k);
        end
      end
    end
    en[1] = 1'b0;
    chk("b2b_pulses", 32'(pulses), 32'd4);
    @(posedge clk); #1;
    req(1, 32'hFC, 32'h0, 4'b0000, rd, er, lat);
    chk("below_base_err", 32'(er), 32'd1);
    req(1, 32'h140, 32'h0, 4'b0000, rd, er, lat);
    chk("above_top_err", 32'(er), 32'd1);
    req(1, 32'h13C, 32'h0, 4'b0000, rd, er, lat);
    chk("top_word_err", 32'(er), 32'd0);

    // Three wait states: reset in the middle of a write drops it.
    req(2, 32'h30, 32'h0102_0304, 4'b1111, rd, er, lat);
    chk("ws3_lat", 32'(lat), 32'd4);
    en[2] = 1'b1; addr[2] = 32'h30; wdata[2] = 32'hFFFF_FFFF; mask[2] = 4'b1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[2] = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(rdy[2]), 32'd0);
    en[2] = 1'b0; mask[2] = 4'b0000;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (rdy[2]) pulses++;
    end
    chk("rst_no_ready", 32'(pulses), 32'd0);
    req(2, 32'h30, 32'h0, 4'b0000, rd, er, lat);
    chk("rst_old_value", rd, 32'h0102_0304);
    req(2, 32'h34, 32'h5566_7788, 4'b1111, rd, er, lat);
    req(2, 32'h38, 32'h0, 4'b1111, rd, er, lat);
    req(2, 32'h3C, 32'h0, 4'b1111, rd, er, lat);
    req(2, 32'h34, 32'h0, 4'b0000, rd, er, lat);
    chk("ws3_rd_data", rd, 32'h5566_7788);
    req(2, 32'h31, 32'h0, 4'b0000, rd, er, lat);
    chk("ws3_err", 32'(er), 32'd1);
`ifdef API_DMEM_STATS_EN
    chk("stats_wr", wrc[2], 32'd3);
    chk("stats_rd", rdc[2], 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the core's data-memory port.
- Accepts single-word read/write requests from the core, which drives enable, address, write data and a 4-bit byte write mask.
- Returns read data and a one-cycle ready pulse after a programmable number of wait states.
- Sits between the RV32IM core and the data storage; replaces the zero-wait RAM model in system benches.

Parameters:
- ADDR_WIDTH, 32, request address width (byte address).
- DATA_WIDTH, 32, data word width; fixed at 32, with 4 byte lanes.
- DEPTH_WORDS, 1024, number of 32-bit words in storage; must be a power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_STATES, 1, extra cycles between accept and response; range 0..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- en_i  in  1  request valid; held high by the initiator until ready_o.
- addr_i  in  ADDR_WIDTH  byte address of the request.
- data_i  in  32  write data, byte lanes aligned to the mask.
- wr_mask_i  in  4  byte write enables; 4'b0000 = read.
- data_o  out  32  read data; valid when ready_o=1 and the request was a read.
- ready_o  out  1  one-cycle response pulse.
- err_o  out  1  response error flag, qualified by ready_o.

Behaviour:
- Reset (async assert, sync release): state=IDLE; ready_o=0, err_o=0, data_o=0; wait counter=0. Storage contents are not cleared.
- FSM states: IDLE, WAIT, RESP (encodings in the package).
- IDLE:
  - en_i=1 captures addr_i, data_i and wr_mask_i into request registers and loads the counter with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, otherwise RESP.
- WAIT: the counter decrements each cycle; when the counter reaches 1, next state is RESP. en_i is ignored (the request is already captured), so a deasserted en_i does not abort it.
- RESP: ready_o=1 for exactly one cycle, then the FSM returns to IDLE.
- Latency: accept edge to ready_o high is WAIT_STATES+1 cycles.
- Back-to-back: the initiator holds en_i across the RESP cycle. IDLE then re-accepts the next cycle; the stale en_i seen during RESP is never treated as a new request. Throughput is one request per WAIT_STATES+2 cycles.
- Write: on entry to RESP, each lane k with wr_mask_i[k]=1 writes data_i[8k+7:8k] to word index (addr−BASE_ADDR)>>2. Unmasked lanes are unchanged.
- Read: data_o is loaded with the full word on entry to RESP. data_o holds its value until the next read response, and is unchanged by writes.
- Error (err_o=1 with ready_o; no storage write; data_o forced to 0):
  - addr[1:0] != 0 (misaligned); or
  - addr < BASE_ADDR; or
  - addr >= BASE_ADDR + 4·DEPTH_WORDS.
- Address arithmetic: the subtraction is unsigned, ADDR_WIDTH wide. A result outside the window must flag an error and must not alias by wrap-around.
- Reset mid-transaction (WAIT or RESP before the edge): the request is dropped, no write occurs, and no ready_o is issued.
- Partial masks are allowed (e.g. 4'b0011 = halfword). Masks are not checked against address alignment beyond addr[1:0].

Optional Feature:
- Macro: API_DMEM_STATS_EN.
- Defined:
  - Adds outputs rd_count_o[31:0] and wr_count_o[31:0].
  - Each counter increments on every non-error read or write response respectively and saturates at 32'hFFFF_FFFF.
  - Counters clear on reset.
- Undefined: these ports and all counter logic are absent; behaviour is otherwise identical.

Decomposition:
- DEFINITIONS.v gains:
  - API_DMEM_IDLE/WAIT/RESP state encodings;
  - API_DMEM_MASK_READ (4'b0000);
  - a lane-count constant.
- Sub-module dmem_array: DEPTH_WORDS×32 synchronous storage with a per-byte write enable, a single port and registered read. The FSM, decode and error logic stay in dmem_responder.

Test Plan:
- WAIT_STATES=1: write 0xDEADBEEF to addr 0x10 with mask 4'b1111, then read 0x10 → ready_o 2 cycles after each accept; data_o=0xDEADBEEF; err_o=0.
- Byte mask: preload 0x11223344 at 0x20, write 0xAABBCCDD with mask 4'b0101, read → 0x11BB33DD.
- Misaligned read 0x22 and out-of-range read 0x1000 (DEPTH_WORDS=1024, BASE_ADDR=0) → err_o=1 with ready_o; data_o=0; storage unchanged on a subsequent read of 0x20.
- WAIT_STATES=0, four back-to-back reads with en_i held high → exactly one ready_o per 2 cycles; no duplicate responses.
- Assert reset during WAIT of a write to 0x30 (WAIT_STATES=3) → no ready_o; reading 0x30 after release returns the old value.
- With API_DMEM_STATS_EN: 3 good writes, 2 good reads, 1 error → wr_count_o=3, rd_count_o=2.
